// File: rtl/dtc_seq_walker.sv
`default_nettype none
// ============================================================================
//  Module   : dtc_seq_walker
//  Purpose  : Table-programmable decision-tree classifier. A config port
//             loads node entries into a register table. Each accepted
//             feature vector is classified by walking the table one node
//             per cycle from root node 0. The 1-bit class is returned on a
//             valid/ready pair.
//  Ports    : clk, rst_n (synchronous, active low)
//             cfg_we/cfg_addr/cfg_data : node-table write (IDLE only)
//             in_valid/in_ready/inp    : feature vector input handshake
//             out_valid/out_ready      : result handshake
//             outp                     : class bit
//             out_err                  : walk aborted (depth overrun or
//                                        bad feature index)
//             busy                     : walk in progress or result pending
//  Entry    : [W-1] is_leaf | [W-2 -: FIW] feat_idx |
//             [2*NODE_AW-1:NODE_AW] right | [NODE_AW-1:0] left
//             For a leaf, bit 0 holds the class.
//  Revision : 1.0  initial release
// ============================================================================
module dtc_seq_walker #(
    parameter int N_FEAT    = 12,
    parameter int FIW       = 4,
    parameter int NODE_AW   = 5,
    parameter int MAX_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_we,
    input  logic [NODE_AW-1:0]             cfg_addr,
    input  logic [1+FIW+2*NODE_AW-1:0]     cfg_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_FEAT-1:0]              inp,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           outp,
    output logic                           out_err,
    output logic                           busy
);

    localparam int             c_W     = 1 + FIW + 2 * NODE_AW;
    localparam int             c_NODES = 2 ** NODE_AW;
    localparam int             c_FEXT  = 2 ** FIW;
    localparam logic [7:0]     c_DMAX  = 8'(MAX_DEPTH - 1);
    localparam logic [FIW:0]   c_NFEAT = (FIW + 1)'(N_FEAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_W-1:0]         r_tbl [c_NODES];
    logic [N_FEAT-1:0]      r_inp;
    logic [NODE_AW-1:0]     r_ptr;
    logic [7:0]             r_depth;
    logic                   r_outp;
    logic                   r_err;

    logic [c_W-1:0]         w_node;
    logic                   w_leaf;
    logic [FIW-1:0]         w_fidx;
    logic                   w_bad_feat;
    logic                   w_depth_hit;
    logic [c_FEXT-1:0]      w_inp_ext;
    logic [NODE_AW-1:0]     w_next;
    logic                   w_accept;
    logic                   w_cfg_wr;

    // Combinational table read of the node currently being visited.
    assign w_node      = r_tbl[r_ptr];
    assign w_leaf      = w_node[c_W-1];
    assign w_fidx      = w_node[c_W-2 -: FIW];
    assign w_bad_feat  = ({1'b0, w_fidx} >= c_NFEAT);
    assign w_depth_hit = (r_depth == c_DMAX);

    // Zero-extend the latched vector so any feat_idx selects a defined bit;
    // out-of-range indices are trapped by w_bad_feat before next is used.
    always_comb begin
        w_inp_ext              = '0;
        w_inp_ext[N_FEAT-1:0]  = r_inp;
    end

    assign w_next = w_inp_ext[w_fidx] ? w_node[2*NODE_AW-1:NODE_AW]
                                      : w_node[NODE_AW-1:0];

    // in_ready is forced low while reset is asserted.
    assign in_ready  = rst_n && (r_state == S_IDLE);
    assign w_accept  = in_ready && in_valid;
    assign w_cfg_wr  = cfg_we && (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_WALK) || (r_state == S_DONE);
    assign outp      = r_outp;
    assign out_err   = r_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = S_WALK;
            S_WALK: if (w_leaf || w_bad_feat || w_depth_hit) w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_inp   <= '0;
            r_ptr   <= '0;
            r_depth <= '0;
            r_outp  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < c_NODES; i++) begin
                r_tbl[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;

            // A write accepted alongside a vector lands at the same edge the
            // walk starts, so the first node evaluation already sees it.
            if (w_cfg_wr) begin
                r_tbl[cfg_addr] <= cfg_data;
            end

            if (w_accept) begin
                r_inp   <= inp;
                r_ptr   <= '0;
                r_depth <= '0;
            end

            if (r_state == S_WALK) begin
                if (w_leaf) begin
                    r_outp <= w_node[0];
                    r_err  <= 1'b0;
                end else if (w_bad_feat || w_depth_hit) begin
                    r_outp <= 1'b0;
                    r_err  <= 1'b1;
                end else begin
                    r_ptr   <= w_next;
                    r_depth <= r_depth + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dtc_seq_walker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dtc_seq_walker
//  Purpose  : Directed self-checking bench for dtc_seq_walker using a small
//             five-node tree with hand-computed classes and latencies.
//             Edge counts include the accept edge as edge 1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dtc_seq_walker;

    localparam int N_FEAT    = 12;
    localparam int FIW       = 4;
    localparam int NODE_AW   = 5;
    localparam int MAX_DEPTH = 8;
    localparam int W         = 1 + FIW + 2 * NODE_AW;

    // Tree: n0={int,f0,L1,R2}, n1=leaf1, n2={int,f5,L3,R4}, n3=leaf0, n4=leaf1
    localparam logic [W-1:0] c_N0      = 15'h0041;
    localparam logic [W-1:0] c_LEAF1   = 15'h4001;
    localparam logic [W-1:0] c_N2      = 15'h1483;
    localparam logic [W-1:0] c_LEAF0   = 15'h4000;
    localparam logic [W-1:0] c_BADFEAT = 15'h3400;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cfg_we;
    logic [NODE_AW-1:0]   cfg_addr;
    logic [W-1:0]         cfg_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [N_FEAT-1:0]    inp;
    logic                 out_valid;
    logic                 out_ready;
    logic                 outp;
    logic                 out_err;
    logic                 busy;

    int n_cmp = 0;
    int n_mis = 0;

    dtc_seq_walker #(
        .N_FEAT    (N_FEAT),
        .FIW       (FIW),
        .NODE_AW   (NODE_AW),
        .MAX_DEPTH (MAX_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp       (inp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outp      (outp),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [NODE_AW-1:0] a, input logic [W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic load_tree;
        cfg_write(5'd0, c_N0);
        cfg_write(5'd1, c_LEAF1);
        cfg_write(5'd2, c_N2);
        cfg_write(5'd3, c_LEAF0);
        cfg_write(5'd4, c_LEAF1);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    // Offers one vector, then counts edges until out_valid (bounded).
    task automatic do_query(input logic [N_FEAT-1:0] v, output int edges,
                            output logic o, output logic e);
        in_valid = 1'b1; inp = v;
        tick;
        edges = 1;
        in_valid = 1'b0; inp = ~v;
        while (!out_valid && edges < 40) begin
            tick;
            edges++;
        end
        o = outp; e = out_err;
    endtask

    task automatic release_result;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        n_cmp++;
        if ({in_ready, out_valid, busy, outp, out_err} !== 5'b0) begin
            n_mis++;
            $display("FAIL reset_outputs: got rdy/vld/busy/outp/err=%b want 00000",
                     {in_ready, out_valid, busy, outp, out_err});
        end
        rst_n = 1'b1;
        tick;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_in_ready_after: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        int   ed;
        logic o, e;
        logic [N_FEAT-1:0] vecs [3] = '{12'h000, 12'h001, 12'h021};
        logic              exp_o [3] = '{1'b1, 1'b0, 1'b1};
        int                exp_ed [3] = '{3, 4, 4};
        load_tree;
        for (int i = 0; i < 3; i++) begin
            do_query(vecs[i], ed, o, e);
            n_cmp++;
            if (o !== exp_o[i] || e !== 1'b0 || ed != exp_ed[i]) begin
                n_mis++;
                $display("FAIL basic_%0d: got outp=%b err=%b edges=%0d want outp=%b err=0 edges=%0d",
                         i, o, e, ed, exp_o[i], exp_ed[i]);
            end
            release_result;
        end
    endtask

    task automatic test_back_to_back;
        logic [N_FEAT-1:0] vecs [3] = '{12'h000, 12'h001, 12'h021};
        logic              res [3];
        int idx = 0, got = 0, iters = 0;
        logic acc;
        out_ready = 1'b1;
        while (got < 3 && iters < 60) begin
            in_valid = (idx < 3);
            inp      = vecs[idx % 3];
            acc      = in_ready && in_valid;
            if (out_valid) begin
                res[got] = outp;
                got++;
            end
            tick;
            iters++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != 3 || res[0] !== 1'b1 || res[1] !== 1'b0 || res[2] !== 1'b1) begin
            n_mis++;
            $display("FAIL b2b_results: got count=%0d r=%b%b%b want count=3 r=101",
                     got, res[0], res[1], res[2]);
        end
        n_cmp++;
        if (iters != 14) begin
            n_mis++;
            $display("FAIL b2b_cycles: got %0d want 14", iters);
        end
        tick;
        tick;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL b2b_no_dup: got out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall;
        int   ed;
        logic o, e;
        do_query(12'h000, ed, o, e);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; inp = 12'h001;
            tick;
            n_cmp++;
            if ({out_valid, in_ready, outp, out_err} !== 4'b1010) begin
                n_mis++;
                $display("FAIL stall_%0d: got vld/rdy/outp/err=%b want 1010",
                         i, {out_valid, in_ready, outp, out_err});
            end
        end
        out_ready = 1'b1;
        tick;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL stall_release: got out_valid=%b in_ready=%b want 0 1",
                     out_valid, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_mis++;
            $display("FAIL stall_no_accept: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_abort;
        int   ed;
        logic o, e;
        do_reset;
        do_query(12'hABC, ed, o, e);
        n_cmp++;
        if (o !== 1'b0 || e !== 1'b1 || ed != MAX_DEPTH + 1) begin
            n_mis++;
            $display("FAIL depth_abort: got outp=%b err=%b edges=%0d want 0 1 %0d",
                     o, e, ed, MAX_DEPTH + 1);
        end
        release_result;
        cfg_write(5'd0, c_BADFEAT);
        do_query(12'hFFF, ed, o, e);
        n_cmp++;
        if (o !== 1'b0 || e !== 1'b1 || ed != 2) begin
            n_mis++;
            $display("FAIL bad_feat: got outp=%b err=%b edges=%0d want 0 1 2", o, e, ed);
        end
        release_result;
    endtask

    task automatic test_cfg_during_walk;
        int   ed;
        logic o, e;
        do_reset;
        load_tree;
        in_valid = 1'b1; inp = 12'h000;
        tick;
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = c_LEAF0;
        tick;
        cfg_we = 1'b0;
        tick;
        n_cmp++;
        if (out_valid !== 1'b1 || outp !== 1'b1 || out_err !== 1'b0) begin
            n_mis++;
            $display("FAIL cfg_walk_dropped: got vld=%b outp=%b err=%b want 1 1 0",
                     out_valid, outp, out_err);
        end
        release_result;
        cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = c_LEAF0;
        in_valid = 1'b1; inp = 12'h000;
        tick;
        cfg_we = 1'b0; in_valid = 1'b0;
        ed = 1;
        while (!out_valid && ed < 40) begin
            tick;
            ed++;
        end
        n_cmp++;
        if (outp !== 1'b0 || out_err !== 1'b0 || ed != 3) begin
            n_mis++;
            $display("FAIL cfg_idle_same_cycle: got outp=%b err=%b edges=%0d want 0 0 3",
                     outp, out_err, ed);
        end
        release_result;
    endtask

    task automatic test_reset_mid_walk;
        int   ed;
        logic o, e;
        logic seen = 1'b0;
        in_valid = 1'b1; inp = 12'h001;
        tick;
        in_valid = 1'b0;
        tick;
        rst_n = 1'b0;
        tick;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL rst_mid_walk: got out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_mis++;
            $display("FAIL rst_abandoned: got stray out_valid=%b want 0", seen);
        end
        do_query(12'h000, ed, o, e);
        n_cmp++;
        if (o !== 1'b0 || e !== 1'b1 || ed != MAX_DEPTH + 1) begin
            n_mis++;
            $display("FAIL rst_table_cleared: got outp=%b err=%b edges=%0d want 0 1 %0d",
                     o, e, ed, MAX_DEPTH + 1);
        end
        release_result;
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        inp       = '0;
        out_ready = 1'b0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_stall;
        test_abort;
        test_cfg_during_walk;
        test_reset_mid_walk;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
